// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared definitions for the memory-stage SRAM controller: state encodings,
// default address map and SRAM data width.
package mem_stage_sram_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOW  = 2'd1;
  localparam state_t ST_HIGH = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam int MEM_BASE_DEFAULT = 1024;
  localparam int SRAM_DW          = 16;

endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// Bundle of the pipeline-side and SRAM-side signals of the memory stage.
//
// Handshake: the pipeline presents mem_read/mem_write with alu_res/val_rm and
// holds them stable for as long as ready is 0. A request is complete in the
// cycle where ready is 1; the pipeline advances on that clock edge. With no
// request, ready is 1 and the stage is transparent.
interface mem_stage_sram_ctrl_if
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int SRAM_AW = 18
);
  // pipeline side
  logic                 mem_read;
  logic                 mem_write;
  logic [31:0]          alu_res;
  logic [31:0]          val_rm;
  logic                 ready;
  logic [31:0]          read_data;
  // SRAM side
  logic [SRAM_AW-1:0]   sram_addr;
  logic                 sram_we_n;
  logic [SRAM_DW-1:0]   sram_dq_out;
  logic                 sram_dq_oe;
  logic [SRAM_DW-1:0]   sram_dq_in;
  // debug view of the controller FSM
  state_t               fsm_state;

  modport slave (
    input  mem_read, mem_write, alu_res, val_rm, sram_dq_in,
    output ready, read_data, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe,
    output fsm_state
  );

  modport master (
    output mem_read, mem_write, alu_res, val_rm, sram_dq_in,
    input  ready, read_data, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe,
    input  fsm_state
  );

endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage controller: performs a 32-bit load/store as two 16-bit
// transfers on an asynchronous SRAM, stalling the pipeline for the access.
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int MEM_BASE      = MEM_BASE_DEFAULT,
  parameter int SRAM_AW       = 18,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_stage_sram_ctrl_if.slave  bus
);

  localparam logic [1:0]  CNT_LOAD = 2'(ACCESS_CYCLES - 1);
  localparam logic [31:0] BASE     = 32'(MEM_BASE);

  state_t             state;
  logic [1:0]         cnt;
  logic [31:0]        read_data;
  logic               req;
  logic               is_write;
  logic               is_read;
  logic               active;
  logic               cnt_zero;
  logic [31:0]        offset;
  logic [SRAM_AW-2:0] word;
  logic               unused_bits;

  // Write wins when both requests are present; a read only captures data
  // when it is not also a write.
  assign req      = bus.mem_read | bus.mem_write;
  assign is_write = bus.mem_write;
  assign is_read  = bus.mem_read & ~bus.mem_write;
  assign active   = (state == ST_LOW) || (state == ST_HIGH);
  assign cnt_zero = (cnt == 2'd0);

  // Byte address to 32-bit word index; low two bits and upper word bits
  // beyond the SRAM range are dropped.
  assign offset      = bus.alu_res - BASE;
  assign word        = offset[SRAM_AW:2];
  assign unused_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  // FSM and per-half cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            state <= ST_LOW;
            cnt   <= CNT_LOAD;
          end
        end
        ST_LOW: begin
          if (cnt_zero) begin
            state <= ST_HIGH;
            cnt   <= CNT_LOAD;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        ST_HIGH: begin
          if (cnt_zero) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Capture each read half on the edge that ends its transfer window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= 32'd0;
    end else if (is_read && cnt_zero) begin
      if (state == ST_LOW) begin
        read_data[15:0] <= bus.sram_dq_in;
      end else if (state == ST_HIGH) begin
        read_data[31:16] <= bus.sram_dq_in;
      end
    end
  end

  // Moore decode of SRAM pins; we_n rises on the last cycle of each half so
  // the address only changes while the write strobe is inactive.
  always_comb begin
    bus.sram_addr   = '0;
    bus.sram_we_n   = 1'b1;
    bus.sram_dq_oe  = 1'b0;
    bus.sram_dq_out = '0;
    if (active) begin
      bus.sram_addr = {word, (state == ST_HIGH)};
      if (is_write) begin
        bus.sram_dq_oe  = 1'b1;
        bus.sram_we_n   = cnt_zero;
        bus.sram_dq_out = (state == ST_HIGH) ? bus.val_rm[31:16] : bus.val_rm[15:0];
      end
    end
  end

  // Pipeline handshake: stall from the request cycle through both halves.
  always_comb begin
    case (state)
      ST_IDLE: bus.ready = ~req;
      ST_DONE: bus.ready = 1'b1;
      default: bus.ready = 1'b0;
    endcase
  end

  assign bus.read_data = read_data;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed testbench for mem_stage_sram_ctrl with a behavioural SRAM and a
// read-data scoreboard.
module tb_mem_stage_sram_ctrl;
  import mem_stage_sram_ctrl_pkg::*;

  logic clk;
  logic rst;

  mem_stage_sram_ctrl_if #(.SRAM_AW(18)) bus ();

  mem_stage_sram_ctrl #(
    .MEM_BASE      (1024),
    .SRAM_AW       (18),
    .ACCESS_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural asynchronous SRAM (64 half-words are enough for the test)
  logic [15:0] sram_mem [0:63];
  always @(posedge clk) begin
    if (!bus.sram_we_n) sram_mem[bus.sram_addr[5:0]] <= bus.sram_dq_out;
  end
  always_comb bus.sram_dq_in = sram_mem[bus.sram_addr[5:0]];

  // scoreboard
  logic [31:0] exp_q[$];
  logic [15:0] model_mem [0:63];
  logic [31:0] last_rd;
  int          n_asserts;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one request, follow it cycle by cycle until ready, check it.
  // Returns at posedge+1 after the DONE cycle with the inputs still applied.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] val, output int cycles);
    logic [31:0] w;
    logic [17:0] lo;
    logic [5:0]  rdy_m, we_m, oe_m;
    logic [17:0] a1, a3;
    logic [15:0] d1, d3;
    logic [31:0] exp;
    bit          done;
    w = (addr - 32'd1024) >> 2;
    lo = {w[16:0], 1'b0};
    rdy_m = '0; we_m = '0; oe_m = '0;
    a1 = '1; a3 = '1; d1 = '1; d3 = '1;
    done = 1'b0;
    cycles = 0;
    if (rd && !wr) exp_q.push_back({model_mem[lo[5:0] + 6'd1], model_mem[lo[5:0]]});
    if (wr) begin
      model_mem[lo[5:0]]        = val[15:0];
      model_mem[lo[5:0] + 6'd1] = val[31:16];
    end
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.alu_res   = addr;
    bus.val_rm    = val;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      cycles = c + 1;
      if (c < 6) begin
        rdy_m[c] = bus.ready;
        we_m[c]  = ~bus.sram_we_n;
        oe_m[c]  = bus.sram_dq_oe;
      end
      if (c == 1) begin a1 = bus.sram_addr; d1 = bus.sram_dq_out; end
      if (c == 3) begin a3 = bus.sram_addr; d3 = bus.sram_dq_out; end
      if (bus.ready) done = 1'b1;
    end
    check("access_cycles", cycles, 6);
    check("ready_pattern", {26'd0, rdy_m}, 32'b100000);
    check("we_low_pattern", {26'd0, we_m}, wr ? 32'b001010 : 32'b0);
    check("oe_pattern", {26'd0, oe_m}, wr ? 32'b011110 : 32'b0);
    check("addr_low_half", {14'd0, a1}, {14'd0, lo});
    check("addr_high_half", {14'd0, a3}, {14'd0, lo[17:1], 1'b1});
    if (wr) begin
      check("dq_out_low", {16'd0, d1}, {16'd0, val[15:0]});
      check("dq_out_high", {16'd0, d3}, {16'd0, val[31:16]});
    end
    check("state_done", {30'd0, bus.fsm_state}, {30'd0, ST_DONE});
    if (rd && !wr) begin
      exp = exp_q.pop_front();
      check("read_data", bus.read_data, exp);
      last_rd = exp;
    end else begin
      check("read_data_hold", bus.read_data, last_rd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.alu_res   = 32'd0;
    bus.val_rm    = 32'd0;
  endtask

  // overall time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n1, n2;

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    last_rd   = 32'd0;
    for (int i = 0; i < 64; i++) model_mem[i] = 16'h0000;
    go_idle();

    // reset state
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", bus.ready, 1);
    check("rst_we_n", bus.sram_we_n, 1);
    check("rst_oe", bus.sram_dq_oe, 0);
    check("rst_addr", {14'd0, bus.sram_addr}, 0);
    check("rst_read_data", bus.read_data, 0);
    check("rst_state", {30'd0, bus.fsm_state}, {30'd0, ST_IDLE});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // write 0xDEADBEEF at byte 1032 -> half-words 4/5
    do_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, n1);
    go_idle();
    check("sram_word4", {16'd0, sram_mem[4]}, 32'h0000BEEF);
    check("sram_word5", {16'd0, sram_mem[5]}, 32'h0000DEAD);
    @(posedge clk); #1;

    // read it back
    do_access(1'b1, 1'b0, 32'd1032, 32'd0, n1);
    go_idle();
    @(posedge clk); #1;

    // address edge: base address, and base with low byte bits set
    do_access(1'b0, 1'b1, 32'd1024, 32'h0BADF00D, n1);
    go_idle();
    @(posedge clk); #1;
    do_access(1'b1, 1'b0, 32'd1027, 32'd0, n1);
    go_idle();

    // no request for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", bus.ready, 1);
      check("idle_we_n", bus.sram_we_n, 1);
      check("idle_oe", bus.sram_dq_oe, 0);
      check("idle_read_data", bus.read_data, last_rd);
    end
    @(posedge clk); #1;

    // back-to-back write then read, second starts right after DONE
    do_access(1'b0, 1'b1, 32'd1040, 32'hCAFE1234, n1);
    do_access(1'b1, 1'b0, 32'd1040, 32'd0, n2);
    go_idle();
    check("back_to_back_total", n1 + n2, 12);
    @(posedge clk); #1;

    // both requests: behaves as a write, read_data untouched
    do_access(1'b1, 1'b1, 32'd1048, 32'h12345678, n1);
    go_idle();
    @(posedge clk); #1;
    do_access(1'b1, 1'b0, 32'd1048, 32'd0, n1);
    go_idle();
    @(posedge clk); #1;

    // asynchronous reset during the HIGH half of a write
    bus.mem_write = 1'b1;
    bus.alu_res   = 32'd1056;
    bus.val_rm    = 32'hAAAA5555;
    repeat (4) @(negedge clk);
    check("pre_rst_state", {30'd0, bus.fsm_state}, {30'd0, ST_HIGH});
    check("pre_rst_we_n", bus.sram_we_n, 0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_we_n", bus.sram_we_n, 1);
    check("async_rst_oe", bus.sram_dq_oe, 0);
    check("async_rst_ready", bus.ready, 0);
    check("async_rst_state", {30'd0, bus.fsm_state}, {30'd0, ST_IDLE});
    check("async_rst_read_data", bus.read_data, 0);
    last_rd = 32'd0;
    go_idle();
    #1;
    check("rst_idle_ready", bus.ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    do_access(1'b1, 1'b0, 32'd1032, 32'd0, n1);
    go_idle();
    @(posedge clk); #1;

    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
